// File: rtl/ctrl_burst_data.sv
// Data-window sequencer: queues issued CAS commands, counts down their latency and drives
// the read/write data windows with end-of-burst and auto-precharge strobes.
module ctrl_burst_data #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       CK_t,
    input  logic       reset_n,
    input  logic       cas_rdy,
    input  logic [2:0] cas_req,
    input  logic [4:0] CL,
    input  logic [4:0] CWL,
    input  logic [4:0] AL,
    input  logic [4:0] BL,
    output logic       rd_en,
    output logic       wr_en,
    output logic       rw_done,
    output logic       ap_done,
    output logic       data_busy,
    output logic       err_overflow,
    output logic       err_overlap
);

    localparam logic [2:0] RD_R  = 3'd0;
    localparam logic [2:0] RDA_R = 3'd1;
    localparam logic [2:0] WR_R  = 3'd2;
    localparam logic [2:0] WRA_R = 3'd3;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic       is_write;
        logic       is_ap;
        logic       bl8;
        logic [5:0] cd;
    } entry_t;

    typedef enum logic [1:0] {DATA_IDLE, DATA_BURST, DATA_LAST} state_t;

    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic             cur_wr_q, cur_wr_d;
    logic             cur_ap_q, cur_ap_d;
    logic             cur_bl8_q, cur_bl8_d;

    logic             req_wr, req_ap;
    logic [5:0]       lat;
    entry_t           new_entry;
    logic             head_due, pop, push, full;
    logic             start, overlap_set;
    logic [PTR_W-1:0] wr_idx;

    function automatic entry_t dec_entry(input entry_t e);
        entry_t r;
        r    = e;
        r.cd = (e.cd != 6'd0) ? e.cd - 6'd1 : 6'd0;
        return r;
    endfunction

    always_comb begin
        req_wr = 1'b0;
        req_ap = 1'b0;
        case (cas_req)
            RD_R:    begin req_wr = 1'b0; req_ap = 1'b0; end
            RDA_R:   begin req_wr = 1'b0; req_ap = 1'b1; end
            WR_R:    begin req_wr = 1'b1; req_ap = 1'b0; end
            WRA_R:   begin req_wr = 1'b1; req_ap = 1'b1; end
            default: begin req_wr = 1'b0; req_ap = 1'b0; end
        endcase
        lat                = {1'b0, AL} + (req_wr ? {1'b0, CWL} : {1'b0, CL});
        new_entry.is_write = req_wr;
        new_entry.is_ap    = req_ap;
        new_entry.bl8      = (BL == 5'd8);
        new_entry.cd       = lat - 6'd1;
    end

    // Head is due one cycle ahead of countdown 0 so the registered enables land on k+L.
    always_comb begin
        head_due = (count_q != '0) && (fifo_q[0].cd <= 6'd1);
        pop      = head_due;
        full     = (count_q == CNT_W'(DEPTH));
        push     = cas_rdy && (!full || pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_idx   = PTR_W'(count_q - CNT_W'(pop));
        for (int i = 0; i < DEPTH; i++) begin
            fifo_d[i] = dec_entry(fifo_q[i]);
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_d[i] = dec_entry(fifo_q[i + 1]);
            end
        end
        if (push) begin
            fifo_d[wr_idx] = new_entry;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cur_wr_d    = cur_wr_q;
        cur_ap_d    = cur_ap_q;
        cur_bl8_d   = cur_bl8_q;
        start       = 1'b0;
        overlap_set = 1'b0;
        case (state_q)
            DATA_IDLE: begin
                start = head_due;
            end
            DATA_BURST: begin
                overlap_set = head_due;
                if (beat_q == (cur_bl8_q ? 2'd2 : 2'd0)) begin
                    state_d = DATA_LAST;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            DATA_LAST: begin
                start = head_due;
                if (!head_due) begin
                    state_d = DATA_IDLE;
                end
            end
            default: state_d = DATA_IDLE;
        endcase
        if (start) begin
            state_d   = DATA_BURST;
            beat_d    = 2'd0;
            cur_wr_d  = fifo_q[0].is_write;
            cur_ap_d  = fifo_q[0].is_ap;
            cur_bl8_d = fifo_q[0].bl8;
        end
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= DATA_IDLE;
            count_q      <= '0;
            beat_q       <= 2'd0;
            cur_wr_q     <= 1'b0;
            cur_ap_q     <= 1'b0;
            cur_bl8_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_en        <= 1'b0;
            wr_en        <= 1'b0;
            rw_done      <= 1'b0;
            ap_done      <= 1'b0;
            data_busy    <= 1'b0;
            err_overflow <= 1'b0;
            err_overlap  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            cur_wr_q     <= cur_wr_d;
            cur_ap_q     <= cur_ap_d;
            cur_bl8_q    <= cur_bl8_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            rd_en        <= (state_d != DATA_IDLE) && !cur_wr_d;
            wr_en        <= (state_d != DATA_IDLE) && cur_wr_d;
            rw_done      <= (state_d == DATA_LAST);
            ap_done      <= (state_d == DATA_LAST) && cur_ap_d;
            data_busy    <= (count_d != '0) || (state_d != DATA_IDLE);
            err_overflow <= err_overflow || (cas_rdy && full && !pop);
            err_overlap  <= err_overlap || overlap_set;
        end
    end

endmodule

// File: tb/tb_ctrl_burst_data.sv
// Randomized and directed bench for ctrl_burst_data against an absolute-time queue model.
module tb_ctrl_burst_data;

    localparam int DEPTH = 4;
    localparam logic [2:0] RD_R  = 3'd0;
    localparam logic [2:0] RDA_R = 3'd1;
    localparam logic [2:0] WR_R  = 3'd2;
    localparam logic [2:0] WRA_R = 3'd3;

    logic       CK_t    = 1'b0;
    logic       reset_n = 1'b0;
    logic       cas_rdy = 1'b0;
    logic [2:0] cas_req = RD_R;
    logic [4:0] CL = 5'd11, CWL = 5'd9, AL = 5'd0, BL = 5'd8;
    logic       rd_en, wr_en, rw_done, ap_done, data_busy, err_overflow, err_overlap;

    ctrl_burst_data #(.DEPTH(DEPTH)) dut (
        .CK_t(CK_t), .reset_n(reset_n), .cas_rdy(cas_rdy), .cas_req(cas_req),
        .CL(CL), .CWL(CWL), .AL(AL), .BL(BL),
        .rd_en(rd_en), .wr_en(wr_en), .rw_done(rw_done), .ap_done(ap_done),
        .data_busy(data_busy), .err_overflow(err_overflow), .err_overlap(err_overlap)
    );

    always #5 CK_t = ~CK_t;

    // Model entry: absolute cycle the window must open, plus burst attributes.
    typedef struct {
        int due;
        bit wr;
        bit ap;
        int beats;
    } ment_t;

    ment_t mq[$];
    int    cyc = 0;
    int    win_s = 0, win_e = -1;
    bit    cur_wr = 0, cur_ap = 0, m_ovf = 0, m_ovl = 0;
    int    total = 0, bad = 0;
    bit    tracing = 0;
    int    base = 0;
    logic [63:0] tr_rd, tr_wr, tr_done, tr_ap, tr_ovf, tr_ovl, tr_busy;

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic bit act(input int x);
        return (x >= win_s) && (x <= win_e);
    endfunction

    task automatic model_reset();
        mq.delete();
        win_s = 0;
        win_e = -1;
        m_ovf = 0;
        m_ovl = 0;
    endtask

    // Applies the inputs of cycle cyc; the model then describes cycle cyc+1.
    task automatic model_step();
        ment_t e;
        bit    pop;
        int    sz;
        int    l;
        sz  = mq.size();
        pop = 0;
        if (sz > 0) pop = (mq[0].due <= cyc + 1);
        if (pop) begin
            e = mq.pop_front();
            if (act(cyc) && cyc < win_e) begin
                m_ovl = 1;
            end else begin
                win_s  = cyc + 1;
                win_e  = cyc + e.beats;
                cur_wr = e.wr;
                cur_ap = e.ap;
            end
        end
        if (cas_rdy) begin
            if (sz == DEPTH && !pop) begin
                m_ovf = 1;
            end else begin
                e.wr    = (cas_req == WR_R) || (cas_req == WRA_R);
                e.ap    = (cas_req == RDA_R) || (cas_req == WRA_R);
                l       = int'(AL) + (e.wr ? int'(CWL) : int'(CL));
                e.due   = cyc + l;
                e.beats = (BL == 5'd8) ? 4 : 2;
                mq.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic compare();
        bit a;
        int idx;
        a = act(cyc);
        chk1("rd_en", rd_en, a && !cur_wr);
        chk1("wr_en", wr_en, a && cur_wr);
        chk1("rw_done", rw_done, a && (cyc == win_e));
        chk1("ap_done", ap_done, a && (cyc == win_e) && cur_ap);
        chk1("data_busy", data_busy, (mq.size() != 0) || a);
        chk1("err_overflow", err_overflow, m_ovf);
        chk1("err_overlap", err_overlap, m_ovl);
        idx = cyc - base;
        if (tracing && idx >= 0 && idx < 64) begin
            tr_rd[idx]   = rd_en;
            tr_wr[idx]   = wr_en;
            tr_done[idx] = rw_done;
            tr_ap[idx]   = ap_done;
            tr_ovf[idx]  = err_overflow;
            tr_ovl[idx]  = err_overlap;
            tr_busy[idx] = data_busy;
        end
    endtask

    task automatic tick();
        @(posedge CK_t);
        if (reset_n) begin
            model_step();
        end else begin
            model_reset();
            cyc++;
        end
        @(negedge CK_t);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cas(input logic [2:0] req);
        cas_rdy = 1'b1;
        cas_req = req;
        tick();
        cas_rdy = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle, held across two edges.
    task automatic rst_pulse();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic start_trace();
        rst_pulse();
        tr_rd = '0; tr_wr = '0; tr_done = '0; tr_ap = '0;
        tr_ovf = '0; tr_ovl = '0; tr_busy = '0;
        base    = cyc;
        tracing = 1;
        AL = 5'd0; CL = 5'd11; CWL = 5'd9; BL = 5'd8;
    endtask

    initial begin
        model_reset();
        @(negedge CK_t);
        compare();
        tick();
        tick();
        reset_n = 1'b1;

        // Single read, L=11, BL=8
        start_trace();
        cas(RD_R);
        idle(20);
        chk64("single_rd rd_en", tr_rd, 64'h7800);
        chk64("single_rd rw_done", tr_done, 64'h4000);
        chk64("single_rd ap_done", tr_ap, 64'h0);
        chk64("single_rd wr_en", tr_wr, 64'h0);

        // WRA_R, CWL=9
        start_trace();
        cas(WRA_R);
        idle(20);
        chk64("wra wr_en", tr_wr, 64'h1E00);
        chk64("wra rw_done", tr_done, 64'h1000);
        chk64("wra ap_done", tr_ap, 64'h1000);

        // Seamless back-to-back reads
        start_trace();
        cas(RD_R);
        idle(3);
        cas(RD_R);
        idle(20);
        chk64("b2b rd_en", tr_rd, 64'h7F800);
        chk64("b2b rw_done", tr_done, 64'h44000);
        chk64("b2b err_overlap", tr_ovl, 64'h0);

        // Second read due mid-burst
        start_trace();
        cas(RD_R);
        idle(1);
        cas(RD_R);
        idle(28);
        chk64("overlap rd_en", tr_rd, 64'h7800);
        chk64("overlap rw_done", tr_done, 64'h4000);
        chk64("overlap err_overlap", tr_ovl, 64'h0000_0000_FFFF_E000);

        // Five pulses into a four-deep tracker; AL staggers the windows back-to-back
        start_trace();
        CL = 5'd20;
        for (int i = 0; i < 5; i++) begin
            AL = 5'(3 * i);
            cas(RD_R);
        end
        idle(34);
        chk64("ovf err_overflow", tr_ovf, 64'h0000_00FF_FFFF_FFE0);
        chk64("ovf rd_en", tr_rd, 64'h0000_000F_FFF0_0000);
        chk64("ovf rw_done", tr_done, 64'h0000_0008_8880_0000);
        chk64("ovf err_overlap", tr_ovl, 64'h0);

        // Reset in cycle 12 of a single read
        start_trace();
        cas(RD_R);
        idle(11);
        chk1("abort rd_en before", rd_en, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("abort rd_en immediate", rd_en, 1'b0);
        chk1("abort data_busy immediate", data_busy, 1'b0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        idle(10);
        chk64("abort rw_done", tr_done, 64'h0);
        chk1("abort data_busy after", data_busy, 1'b0);
        tracing = 0;

        // Randomized traffic, light then heavy, with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if (i % 900 == 899) rst_pulse();
            cas_rdy = ($urandom_range((i < 2000) ? 4 : 1) == 0);
            cas_req = 3'($urandom_range(3));
            AL      = 5'($urandom_range(4));
            CL      = 5'($urandom_range(14, 2));
            CWL     = 5'($urandom_range(12, 2));
            BL      = ($urandom_range(1) == 1) ? 5'd8 : 5'd4;
            tick();
        end
        cas_rdy = 1'b0;
        idle(80);
        chk1("drain data_busy", data_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_burst_data.md
CTRL_BURST_DATA -- requirements
Module: ctrl_burst_data

Interface
REQ-001 Parameter: DEPTH, 4, number of outstanding CAS commands tracked (power of two, 2..8).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; ports are as follows (clock and reset first).
REQ-003 CK_t  in  1  controller clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cas_rdy  in  1  one-cycle pulse from the CAS stage: a CAS is issued this cycle.
REQ-006 cas_req  in  3  request type with cas_rdy: RD_R, RDA_R, WR_R or WRA_R (ddr_pkg encodings).
REQ-007 CL, CWL, AL  in  5 each  programmed latencies in clocks.
REQ-008 BL  in  5  burst length, 4 or 8.
REQ-009 rd_en  out  1  read data window active.
REQ-010 wr_en  out  1  write data window active.
REQ-011 rw_done  out  1  one-cycle pulse on the last beat of each burst; feeds the CAS stage.
REQ-012 ap_done  out  1  pulses with rw_done when the completing burst was RDA_R or WRA_R.
REQ-013 data_busy  out  1  high while any entry is pending or a burst is active.
REQ-014 err_overflow  out  1  sticky: cas_rdy arrived with the tracker full.
REQ-015 err_overlap  out  1  sticky: a burst became due while another burst was mid-window.

Function
REQ-016 Latency: L = AL+CL for reads (RD_R/RDA_R) and L = AL+CWL for writes (WR_R/WRA_R), computed in 6 bits without truncation.
REQ-017 Accepted cas_rdy in cycle k: the data window SHALL span cycles k+L .. k+L+BL/2-1; rd_en or wr_en high exactly in those cycles.
REQ-018 rw_done SHALL be high only in cycle k+L+BL/2-1; ap_done likewise for auto-precharge types.
REQ-019 Tracker: DEPTH-entry FIFO of {is_write, is_ap, countdown}; on push, countdown = L-1; every cycle each valid entry's countdown decrements by 1, saturating at 0.
REQ-020 The head entry at countdown 0 SHALL pop and start a burst in that cycle's following edge alignment per REQ-017.
REQ-021 Simultaneous push and pop in one cycle SHALL both occur; occupancy is unchanged.
REQ-022 Full: cas_rdy with DEPTH entries and no pop in the same cycle SHALL be dropped and SHALL set err_overflow; with a same-cycle pop it SHALL be accepted.
REQ-023 Burst FSM states: DATA_IDLE, DATA_BURST, DATA_LAST.
REQ-024 DATA_IDLE -> DATA_BURST when head due (BL=8); DATA_IDLE -> DATA_LAST when head due and BL=4 is not applicable (BL/2=2 uses DATA_BURST for one beat).
REQ-025 DATA_BURST: beat counter increments; enters DATA_LAST when the counter reaches BL/2-2.
REQ-026 DATA_LAST: rw_done pulses; if the next head is due this cycle, go directly to DATA_BURST (seamless back-to-back, no gap); otherwise go to DATA_IDLE.
REQ-027 Head due while in DATA_BURST SHALL set err_overlap, drop that entry and keep the current burst unchanged.
REQ-028 rd_en/wr_en SHALL never be high in the same cycle.
REQ-029 CL, CWL, AL and BL SHALL be sampled at push time per entry; later changes do not affect queued entries.
REQ-030 L < 2 is unsupported; behaviour is undefined.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 reset_n low SHALL immediately force: FSM DATA_IDLE, FIFO empty, beat counter 0, rd_en/wr_en/rw_done/ap_done/data_busy 0, err_overflow/err_overlap 0.
REQ-033 Reset mid-burst SHALL abort the burst with no rw_done; the first edge after release behaves as from DATA_IDLE.

Verification
REQ-034 Single read, AL=0, CL=11, BL=8, cas_rdy cycle 0 -> rd_en cycles 11-14, rw_done cycle 14 only, ap_done 0.
REQ-035 WRA_R, AL=0, CWL=9, BL=8, cas_rdy cycle 0 -> wr_en cycles 9-12, rw_done and ap_done cycle 12.
REQ-036 Two reads CL=11 BL=8, cas_rdy cycles 0 and 4 -> rd_en continuous cycles 11-18, rw_done cycles 14 and 18, no err_overlap.
REQ-037 Reads at cycles 0 and 2, CL=11 BL=8 -> second due mid-burst, err_overlap set cycle 13, single rw_done at cycle 14.
REQ-038 DEPTH=4, five cas_rdy pulses cycles 0-4 with CL=20 -> fifth dropped, err_overflow set, four bursts complete.
REQ-039 reset_n low at cycle 12 of REQ-034 -> rd_en 0 immediately, no rw_done, data_busy 0 after release.
